// File: rtl/cic_decim_mch.sv
// Multi-channel CIC decimator. All channels share one rate counter, one flush
// counter and one pipeline tag chain; each channel has its own integrators,
// sampler, comb stages with differential delay M, and a round/saturate output.
module cic_decim_mch #(
    parameter int NCH           = 2,
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 16,
    parameter int N             = 5,
    parameter int M             = 2,
    parameter int MAXRATE       = 64,
    parameter int BITGROWTH     = 35,
    parameter int RATE_WIDTH    = 7,
    parameter int DEFAULT_RATE  = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [NCH*DATAIN_WIDTH-1:0]  data_i,
    input  logic                         valid_i,
    input  logic [RATE_WIDTH-1:0]        ratio_i,
    input  logic                         ratio_wr_i,
    output logic [RATE_WIDTH-1:0]        ratio_o,
    output logic [NCH*DATAOUT_WIDTH-1:0] data_o,
    output logic                         valid_o,
    output logic [NCH-1:0]               sat_o
);

    localparam int W     = DATAIN_WIDTH + BITGROWTH;
    localparam int S     = W - DATAOUT_WIDTH;
    localparam int FLUSH = N * M;
    localparam int FW    = $clog2(FLUSH + 1);
    localparam int DEF_CLAMPED = (DEFAULT_RATE < 2) ? 2 :
                                 (DEFAULT_RATE > MAXRATE) ? MAXRATE : DEFAULT_RATE;

    logic [RATE_WIDTH-1:0] ratio_clamped;
    logic [RATE_WIDTH-1:0] cnt;
    logic [FW-1:0]         flush_cnt;
    logic                  tick;
    logic [N+1:0]          stg_v;   // bit i: stage i (0 = sampler, 1..N = combs, N+1 = round) updated last edge
    logic [N+1:0]          stg_e;   // matching tag: this tick is outside the flush window
    logic                  emit;

    // Clamp the requested ratio into the supported range.
    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no latch is inferred.
        ratio_clamped = ratio_i;
        if (ratio_i < RATE_WIDTH'(2))
            ratio_clamped = RATE_WIDTH'(2);
        else if (int'(ratio_i) > MAXRATE)
            ratio_clamped = RATE_WIDTH'(MAXRATE);
    end

    // A sample strobe coincident with a ratio write never counts toward the new frame.
    assign tick = valid_i && !ratio_wr_i && (cnt == ratio_o - RATE_WIDTH'(1));
    assign emit = stg_v[N+1] && stg_e[N+1] && !ratio_wr_i;

    // Ratio register, rate counter and flush counter.
    always_ff @(posedge clk_i) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n_i) begin
            ratio_o   <= RATE_WIDTH'(DEF_CLAMPED);
            cnt       <= '0;
            flush_cnt <= '0;
        end else if (ratio_wr_i) begin
            ratio_o   <= ratio_clamped;
            cnt       <= '0;
            flush_cnt <= FW'(FLUSH);
        end else begin
            if (valid_i)
                cnt <= tick ? '0 : cnt + RATE_WIDTH'(1);
            if (tick && flush_cnt != '0)
                flush_cnt <= flush_cnt - FW'(1);
        end
    end

    // Tag chain tracking which pipeline stage updates next; a write drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || ratio_wr_i) begin
            stg_v <= '0;
            stg_e <= '0;
        end else begin
            stg_v <= {stg_v[N:0], tick};
            stg_e <= {stg_e[N:0], flush_cnt == '0};
        end
    end

    // Shared output strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) valid_o <= 1'b0;
        else          valid_o <= emit;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic signed [DATAIN_WIDTH-1:0]  x_in;
        logic signed [W-1:0]             integ [N];
        logic signed [W-1:0]             samp;
        logic signed [W-1:0]             comb  [N];
        logic signed [W-1:0]             comb_in [N];
        logic signed [W-1:0]             dly   [N][M];
        logic signed [W:0]               full_ext;
        logic signed [DATAOUT_WIDTH:0]   q_next;
        logic signed [DATAOUT_WIDTH:0]   q;
        logic [DATAOUT_WIDTH-1:0]        dout;
        logic                            sat;

        assign x_in     = data_i[k*DATAIN_WIDTH +: DATAIN_WIDTH];
        assign comb_in[0] = samp;
        for (genvar i = 1; i < N; i++) begin : g_cin
            assign comb_in[i] = comb[i-1];
        end
        assign full_ext = {comb[N-1][W-1], comb[N-1]};

        if (S > 0) begin : g_rnd
            logic signed [W:0] rnd_sum;
            assign rnd_sum = full_ext + ((W+1)'(1) <<< (S-1));
            assign q_next  = rnd_sum[W:S];
        end else begin : g_nornd
            assign q_next = full_ext;
        end

        // Integrator cascade, wrapping modulo 2^W, advancing only on valid_i.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                for (int i = 0; i < N; i++) integ[i] <= '0;
            end else if (valid_i) begin
                integ[0] <= integ[0] + W'(x_in);
                for (int i = 1; i < N; i++) integ[i] <= integ[i] + integ[i-1];
            end
        end

        // Decimating sampler takes the last integrator before this edge's update.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i || ratio_wr_i) samp <= '0;
            else if (tick)              samp <= integ[N-1];
        end

        // Comb stages, each firing one cycle after its predecessor.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                // NOTE: delay lines are a handful of registers, so they take the same clear as all other state.
                for (int i = 0; i < N; i++) begin
                    comb[i] <= '0;
                    for (int j = 0; j < M; j++) dly[i][j] <= '0;
                end
            end else if (ratio_wr_i) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < M; j++) dly[i][j] <= '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (stg_v[i]) begin
                        comb[i]   <= comb_in[i] - dly[i][M-1];
                        dly[i][0] <= comb_in[i];
                        for (int j = 1; j < M; j++) dly[i][j] <= dly[i][j-1];
                    end
                end
            end
        end

        // Rounding register between the last comb and the saturating output.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i)      q <= '0;
            else if (stg_v[N]) q <= q_next;
        end

        // Saturating output register; holds between strobes.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                dout <= '0;
                sat  <= 1'b0;
            end else if (emit) begin
                if (q[DATAOUT_WIDTH] != q[DATAOUT_WIDTH-1]) begin
                    dout <= q[DATAOUT_WIDTH] ? {1'b1, {(DATAOUT_WIDTH-1){1'b0}}}
                                             : {1'b0, {(DATAOUT_WIDTH-1){1'b1}}};
                    sat  <= 1'b1;
                end else begin
                    dout <= q[DATAOUT_WIDTH-1:0];
                    sat  <= 1'b0;
                end
            end
        end

        assign data_o[k*DATAOUT_WIDTH +: DATAOUT_WIDTH] = dout;
        assign sat_o[k] = sat;
    end

endmodule
